// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial sequence detector (KMP prefix automaton).
// Recognises PATTERN (MSB received first) on a 1-bit stream, overlapping or
// non-overlapping matching chosen by ovl on the completing edge.
// Optional saturating match counter: define SEQ_DET_CNT_EN to build it;
// otherwise match_cnt is tied to zero.
module seq_det_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b0110,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in,
  input  logic                       ovl,
  output logic                       out,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(SEQ_LEN)-1:0] state
);

  localparam int SW = $clog2(SEQ_LEN);
  localparam int NS = 1 << SW;

  // Pattern character i in arrival order (i=0 is the first bit received).
  function automatic logic pat_char(input int i);
    if (i >= 0 && i < SEQ_LEN) return PATTERN[SEQ_LEN-1-i];
    return 1'b0;
  endfunction

  // Longest proper (< SEQ_LEN) suffix of "prefix s followed by b" that is also
  // a pattern prefix. On a match at s=SEQ_LEN-1 this yields the pattern border,
  // which is exactly the restart point for overlapping mode.
  function automatic int next_len(input int s, input int b);
    int  best;
    int  idx;
    logic ok;
    logic c;
    best = 0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          idx = s + 1 - k + j;
          c   = (idx == s) ? b[0] : pat_char(idx);
          if (pat_char(j) != c) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Transition and expected-bit tables, fixed at elaboration from PATTERN.
  logic [NS-1:0][1:0][SW-1:0] nxt_tbl;
  logic [NS-1:0]              exp_tbl;

  for (genvar s = 0; s < NS; s++) begin : g_tbl
    localparam int N0 = (s < SEQ_LEN) ? next_len(s, 0) : 0;
    localparam int N1 = (s < SEQ_LEN) ? next_len(s, 1) : 0;
    assign nxt_tbl[s][0] = SW'(N0);
    assign nxt_tbl[s][1] = SW'(N1);
    assign exp_tbl[s]    = pat_char(s);
  end

  logic [SW-1:0] state_q, state_d;
  logic          out_q, out_d;
  logic          done;

  // Next state: table lookup on enabled bits; non-overlap restarts from zero.
  always_comb begin
    done    = (in == exp_tbl[state_q]) && (state_q == SW'(SEQ_LEN-1));
    state_d = state_q;
    out_d   = 1'b0;
    if (en) begin
      state_d = nxt_tbl[state_q][in];
      if (done) begin
        out_d = 1'b1;
        if (!ovl) state_d = '0;
      end
    end
  end

  // State and match pulse registers; reset discards any partial match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match count: holds at all-ones, pulses keep coming.
  always_comb begin
    cnt_d = cnt_q;
    if (en && done && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  assign out   = out_q;
  assign state = state_q;

endmodule
